// File: rtl/st2mm_cpl_gen.sv
// -----------------------------------------------------------------------------
// st2mm_cpl_gen
//
// Completion generator for the st2mm MMIO read path. When a read is issued,
// its completion header info is stored in a table indexed by the low bits of
// the tag. When the AXI-MM read response arrives, it is matched by rid. On a
// hit, one single-beat PCIe SS completion is emitted on the AXI-S TX port:
// CplD on OKAY/EXOKAY, or Cpl with CA status on SLVERR/DECERR. Responses that
// match no entry are dropped and flagged.
//
// Optional build macro: ST2MM_CPL_STATS_EN adds saturating event counters.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   info_valid    capture info into the table entry selected by info.tag
//   info          t_cpl_hdr_info of the newly issued read
//   completer_id  function ID placed in every completion
//   mmio_r        AXI-MM read response (rid, rvalid, rresp, rdata)
//   mmio_rready   response accepted when rvalid && rready
//   tx_t*         AXI-S completion beat: header [255:0], payload [319:256]
//   err_orphan    one-cycle pulse: accepted response matched no valid entry
//   err_dup       one-cycle pulse: info written over an already valid entry
//   cpl_cnt, err_cpl_cnt, orphan_cnt, dup_cnt   (ST2MM_CPL_STATS_EN only)
// -----------------------------------------------------------------------------
package pcie_ss_hdr_pkg;
  localparam logic [7:0] FMT_TYPE_CPLD = 8'h4A;
  localparam logic [7:0] FMT_TYPE_CPL  = 8'h0A;
  localparam logic [2:0] CPL_STATUS_SC = 3'b000;
  localparam logic [2:0] CPL_STATUS_CA = 3'b100;

  // Power-user completion header, 256 bits; DW0 occupies bits [31:0].
  typedef struct packed {
    logic [127:0] rsvd_hi;     // [255:128]
    logic [31:0]  rsvd_dw3;    // [127:96]
    logic [15:0]  req_id;      // [95:80]
    logic [7:0]   tag_l;       // [79:72]
    logic         rsvd_dw2;    // [71]
    logic [6:0]   low_addr;    // [70:64]
    logic [15:0]  comp_id;     // [63:48]
    logic [2:0]   cpl_status;  // [47:45]
    logic         bcm;         // [44]
    logic [11:0]  byte_count;  // [43:32]
    logic [7:0]   fmt_type;    // [31:24]
    logic         tag_h;       // [23]
    logic [2:0]   tc;          // [22:20]
    logic         tag_m;       // [19]
    logic         attr_h;      // [18]
    logic [1:0]   rsvd_dw0;    // [17:16]
    logic         td;          // [15]
    logic         ep;          // [14]
    logic [1:0]   attr_l;      // [13:12]
    logic [1:0]   at;          // [11:10]
    logic [9:0]   length;      // [9:0]
  } PCIe_CplHdr_t;
endpackage

package st2mm_pkg;
  localparam int TAG_W = 10;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [6:0]       lower_addr;
    logic [15:0]      requester_id;
    logic [9:0]       length;
    logic [2:0]       attr;
    logic [2:0]       tc;
  } t_cpl_hdr_info;

  localparam int CPL_HDR_INFO_WIDTH = $bits(t_cpl_hdr_info);

  typedef struct packed {
    logic [TAG_W-1:0] rid;
    logic             rvalid;
    logic [1:0]       rresp;
    logic [63:0]      rdata;
  } t_axi_mmio_r;

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

module st2mm_cpl_gen
  import pcie_ss_hdr_pkg::*;
  import st2mm_pkg::*;
#(
  parameter int NUM_TAGS = 64,
  parameter int TDATA_W  = 512
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              info_valid,
  input  logic [CPL_HDR_INFO_WIDTH-1:0]     info,
  input  logic [15:0]                       completer_id,
  input  logic [$bits(t_axi_mmio_r)-1:0]    mmio_r,
  output logic                              mmio_rready,
  output logic                              tx_tvalid,
  input  logic                              tx_tready,
  output logic [TDATA_W-1:0]                tx_tdata,
  output logic [TDATA_W/8-1:0]              tx_tkeep,
  output logic                              tx_tlast,
  output logic                              err_orphan,
  output logic                              err_dup
`ifdef ST2MM_CPL_STATS_EN
  ,
  output logic [15:0]                       cpl_cnt,
  output logic [15:0]                       err_cpl_cnt,
  output logic [15:0]                       orphan_cnt,
  output logic [15:0]                       dup_cnt
`endif
);

  localparam int IDX_W     = $clog2(NUM_TAGS);
  localparam int KEEP_W    = TDATA_W / 8;
  localparam int HDR_BYTES = 32;

  t_cpl_hdr_info        r_entry [NUM_TAGS];
  logic [NUM_TAGS-1:0]  r_vld;

  logic                 r_tvalid;
  logic [TDATA_W-1:0]   r_tdata;
  logic [KEEP_W-1:0]    r_tkeep;
  logic                 r_orphan;
  logic                 r_dup;

  t_cpl_hdr_info        w_info;
  t_axi_mmio_r          w_r;
  t_cpl_hdr_info        w_lu;
  logic [IDX_W-1:0]     w_widx;
  logic [IDX_W-1:0]     w_ridx;
  logic                 w_accept;
  logic                 w_hit;
  logic                 w_is_err;
  PCIe_CplHdr_t         w_hdr;
  logic [63:0]          w_payload;
  logic [KEEP_W-1:0]    w_keep;
  logic [TDATA_W-1:0]   w_tdata;

  assign w_info   = t_cpl_hdr_info'(info);
  assign w_r      = t_axi_mmio_r'(mmio_r);
  assign w_widx   = w_info.tag[IDX_W-1:0];
  assign w_ridx   = w_r.rid[IDX_W-1:0];
  // Lookup reads the pre-write table; a same-cycle write lands on the edge.
  assign w_lu     = r_entry[w_ridx];
  assign w_hit    = r_vld[w_ridx] && (w_lu.tag == w_r.rid);
  assign w_is_err = (w_r.rresp == RESP_SLVERR) || (w_r.rresp == RESP_DECERR);

  // One-deep output stage: accept whenever the slot is empty or draining.
  assign mmio_rready = !r_tvalid || tx_tready;
  assign w_accept    = w_r.rvalid && mmio_rready;

  always_comb begin
    w_hdr                  = '0;
    w_payload              = '0;
    w_keep                 = '0;
    w_keep[HDR_BYTES-1:0]  = '1;
    w_hdr.req_id           = w_lu.requester_id;
    w_hdr.tag_l            = w_lu.tag[7:0];
    w_hdr.tag_m            = w_lu.tag[8];
    w_hdr.tag_h            = w_lu.tag[9];
    w_hdr.low_addr         = w_lu.lower_addr;
    w_hdr.comp_id          = completer_id;
    w_hdr.byte_count       = {w_lu.length, 2'b00};
    w_hdr.tc               = w_lu.tc;
    w_hdr.attr_h           = w_lu.attr[2];
    w_hdr.attr_l           = w_lu.attr[1:0];
    if (w_is_err) begin
      w_hdr.fmt_type   = FMT_TYPE_CPL;
      w_hdr.cpl_status = CPL_STATUS_CA;
      w_hdr.length     = '0;
    end else begin
      w_hdr.fmt_type   = FMT_TYPE_CPLD;
      w_hdr.cpl_status = CPL_STATUS_SC;
      w_hdr.length     = w_lu.length;
      if (w_lu.length == 10'd1) begin
        // A single DW sits in the upper half of the 64-bit bus when addr[2] is set.
        w_payload[31:0]          = w_lu.lower_addr[2] ? w_r.rdata[63:32] : w_r.rdata[31:0];
        w_keep[HDR_BYTES +: 4]   = '1;
      end else begin
        w_payload                = w_r.rdata;
        w_keep[HDR_BYTES +: 8]   = '1;
      end
    end
    w_tdata          = '0;
    w_tdata[255:0]   = w_hdr;
    w_tdata[319:256] = w_payload;
  end

  // Table payload carries no reset; only the valid bits are controlled.
  always_ff @(posedge clk) begin
    if (info_valid) r_entry[w_widx] <= w_info;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      if (w_accept && w_hit) r_vld[w_ridx] <= 1'b0;
      // Placed last so a same-index write overrides the lookup clear.
      if (info_valid)        r_vld[w_widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_orphan <= 1'b0;
      r_dup    <= 1'b0;
    end else begin
      if (w_accept && w_hit) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_tdata;
        r_tkeep  <= w_keep;
      end else if (tx_tready) begin
        r_tvalid <= 1'b0;
      end
      r_orphan <= w_accept && !w_hit;
      r_dup    <= info_valid && r_vld[w_widx];
    end
  end

  assign tx_tvalid  = r_tvalid;
  assign tx_tdata   = r_tdata;
  assign tx_tkeep   = r_tkeep;
  assign tx_tlast   = r_tvalid;
  assign err_orphan = r_orphan;
  assign err_dup    = r_dup;

`ifdef ST2MM_CPL_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic r_is_ca;
  logic w_tx_hs;
  assign w_tx_hs = r_tvalid && tx_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_ca     <= 1'b0;
      cpl_cnt     <= '0;
      err_cpl_cnt <= '0;
      orphan_cnt  <= '0;
      dup_cnt     <= '0;
    end else begin
      if (w_accept && w_hit)        r_is_ca     <= w_is_err;
      if (w_tx_hs && !r_is_ca)      cpl_cnt     <= sat_inc(cpl_cnt);
      if (w_tx_hs && r_is_ca)       err_cpl_cnt <= sat_inc(err_cpl_cnt);
      if (w_accept && !w_hit)       orphan_cnt  <= sat_inc(orphan_cnt);
      if (info_valid && r_vld[w_widx]) dup_cnt  <= sat_inc(dup_cnt);
    end
  end
`endif

endmodule

// File: doc/st2mm_cpl_gen.md
Name: st2mm_cpl_gen

Overview:
- Downstream stage of the st2mm MMIO read path.
- Holds a per-tag table of completion header info (t_cpl_hdr_info) captured when an MMIO read request is issued.
- Consumes AXI-MM read responses (t_axi_mmio_r), matches each by rid, and emits one single-beat PCIe SS completion (CplD on success, Cpl with CA status on error) on an AXI-S TX port.
- Sits between the st2mm AXI-MM read master and the PCIe TX arbiter.

Parameters:
- NUM_TAGS, 64, table depth; index = tag[$clog2(NUM_TAGS)-1:0]; full tag stored and compared.
- TDATA_W, 512, TX data width; header in [255:0], payload in [319:256].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- info_valid  in  1  capture completion info for a newly issued read
- info  in  CPL_HDR_INFO_WIDTH  t_cpl_hdr_info (tag, lower_addr, requester_id, length, attr, tc)
- completer_id  in  16  function ID placed in completions
- mmio_r  in  $bits(t_axi_mmio_r)  read response (rid, rvalid, rresp, rdata)
- mmio_rready  out  1  response accepted when rvalid && rready
- tx_tvalid  out  1  completion beat valid
- tx_tready  in  1  downstream ready
- tx_tdata  out  TDATA_W  PCIe SS power-user header plus payload
- tx_tkeep  out  TDATA_W/8  byte enables
- tx_tlast  out  1  always 1 when tx_tvalid
- err_orphan  out  1  one-cycle pulse: response with no matching valid entry
- err_dup  out  1  one-cycle pulse: info written to an index already valid

Behaviour:
- Reset: table valid bits 0; tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, err_* = 0; mmio_rready = 1.
- Table write: on info_valid, entry[idx] <= info and valid[idx] <= 1 on the next edge.
  - If valid[idx] is already set, overwrite the entry and pulse err_dup.
- Response accept: mmio_rready = !tx_tvalid || tx_tready, a one-deep pipeline with no bubble under continuous tready.
- On an accepted response, look up entry[rid idx]:
  - Hit (valid and stored tag == rid): build completion, load the output register, clear valid[idx]. Latency is exactly 1 cycle from accept to tx_tvalid.
  - Miss: drop the response, pulse err_orphan, leave output unchanged.
- Completion header, packed as pcie_ss_hdr_pkg::PCIe_CplHdr_t:
  - tag, requester_id, attr, tc, lower_addr copied from the entry.
  - completer_id taken from the port.
  - byte_count = length*4.
- rresp OKAY/EXOKAY: fmt_type = CplD (0x4A), status SC (000), length_dw = length.
  - length=2: payload = rdata[63:0], tkeep = header bytes plus 8 payload bytes.
  - length=1: payload DW0 = lower_addr[2] ? rdata[63:32] : rdata[31:0]; tkeep = header bytes plus 4 bytes.
- rresp SLVERR/DECERR: fmt_type = Cpl (0x0A), status CA (100), length_dw = 0, byte_count = length*4, payload zero, tkeep = header bytes only.
- Output hold: tx_* are stable while tx_tvalid && !tx_tready; tx_tvalid clears on tready unless a new completion loads in the same cycle.
- Same-cycle info write and response lookup:
  - The lookup sees the pre-write table.
  - If both target the same index, the write wins: the entry ends valid with the new info.
- Reset mid-operation: pending beat discarded, all table entries invalidated, no partial beat emitted after reset release.

Optional Feature:
- Macro ST2MM_CPL_STATS_EN.
- Defined: adds outputs cpl_cnt[15:0], err_cpl_cnt[15:0], orphan_cnt[15:0], dup_cnt[15:0].
  - Each counts its event (TX handshake for completions; CA completions counted separately).
  - All saturate at 0xFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- info{tag=5, len=2, lower_addr=0x08, req_id=0x0100}, then rid=5 OKAY rdata=0x1122334455667788 → next cycle CplD, byte_count 8, length_dw 2, payload 0x1122334455667788, tag 5, valid[5] cleared.
- info{tag=9, len=1, lower_addr=0x04}, rid=9 OKAY rdata=0xAAAABBBB_CCCCDDDD → CplD payload DW0 0xAAAABBBB, tkeep covers 4 payload bytes.
- rid=7 SLVERR with a valid entry → Cpl, status 100, length_dw 0, byte_count per entry length, no payload bytes in tkeep.
- rid=12 with no entry → no tx beat, err_orphan high for exactly one cycle, mmio_rready stays 1.
- Hold tx_tready=0 for 10 cycles with a beat pending and a second response offered → mmio_rready=0, tx_tdata stable; after tready=1, two beats in order on consecutive cycles.
- Assert rst_n low while tx_tvalid=1 → tx_tvalid drops asynchronously; rid of the old tag after release yields err_orphan.
